reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-back arbiter and scoreboard for the integer register file. It shares the single register-file write port between `NUM_REQ` write-back sources (ALU, load unit, CSR-read path) using valid/ready handshakes, and registers the winning write onto the port. It also tracks which architectural registers have a reserved, pending write so that the issue stage can stall on hazards. It sits between the execute/memory units and the register file's `reg_wr_*` port.

## Interface
- `REG_WIDTH`, 32, data width of a register write.
- `NUM_REQ`, 3, number of write-back requesters; legal range 2..8.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_valid`  in  NUM_REQ  per-requester write request.
- `wb_addr`  in  NUM_REQ x 5  per-requester destination register.
- `wb_data`  in  NUM_REQ x REG_WIDTH  per-requester write data.
- `wb_ready`  out  NUM_REQ  per-requester grant; the request is accepted when `wb_valid[i] & wb_ready[i]`.
- `rsv_en`  in  1  issue stage reserves a destination register.
- `rsv_addr`  in  5  register being reserved.
- `busy`  out  32  per-register pending-write flags; bit 0 is always 0.
- `reg_wr_en`  out  1  write enable to the register file.
- `reg_wr_addr`  out  5  write address to the register file.
- `reg_wr_data`  out  REG_WIDTH  write data to the register file.

## Operation
- Reset values: `reg_wr_en`=0, `reg_wr_addr`=0, `reg_wr_data`=0, `busy`=0, round-robin pointer=0. `wb_ready` is 0 while `rst` is low.
- Grant:
  - At most one `wb_ready` bit is high per cycle.
  - `wb_ready[i]` is high only when `wb_valid[i]` is high, so `wb_ready` is combinational from `wb_valid` and the pointer.
  - The output stage is never stalled, so a valid request is always granted somewhere in the same cycle.
- Round-robin policy:
  - The search starts at the pointer index and wraps modulo `NUM_REQ`.
  - After a grant to index g, the pointer becomes (g+1) mod `NUM_REQ`.
  - The pointer is unchanged when no request is granted.
- Output stage:
  - On acceptance, the registered `reg_wr_en`/`reg_wr_addr`/`reg_wr_data` load the granted request.
  - With no acceptance, `reg_wr_en` goes to 0 and addr/data hold their last values.
- Writes to x0:
  - The request is accepted, `wb_ready` pulses, and the pointer advances.
  - `reg_wr_en` stays 0.
- Scoreboard:
  - `rsv_en` sets `busy[rsv_addr]`.
  - A committed write (`reg_wr_en` high) clears `busy[reg_wr_addr]` at the same edge the register file captures the data.
  - If a set and a clear target the same register in the same cycle, the set wins (a new reservation is outstanding).
  - `rsv_addr`=0 is ignored.
  - A write to a non-busy register is legal and leaves `busy` unchanged.
- Reset asserted mid-operation: all state clears immediately; an in-flight accepted write is dropped (`reg_wr_en` falls asynchronously).

## Timing
- Handshake to port: a request accepted in cycle T appears on `reg_wr_*` in cycle T+1 and is written to the register file at the end of T+1.
- Scoreboard clear: the `busy` bit clears at the end of T+1, so it reads 0 from T+2.
- Scoreboard set: `rsv_en` in cycle T gives `busy` set from T+1.
- Throughput: one write per cycle sustained.
- Fairness: with all `NUM_REQ` requesters continuously valid, each is granted exactly once every `NUM_REQ` cycles.
- `wb_valid` and its payload must stay stable until granted. The arbiter does not check this.

## Configuration
- `TIMBERWOLF_WB_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority, where the lowest index wins. The pointer register is not built, and all other behaviour is identical.

## Structure
- Shared package `timberwolf_pkg` holds:
  - `NUM_ARCH_REG`=32 and `REG_ADDR_WIDTH`=5;
  - typedef `reg_addr_t`;
  - typedef `wb_req_t`, a packed struct of addr and data.
- Sub-module `rr_arbiter`: a generic `NUM_REQ`-way grant generator (one-hot grant plus pointer update). Its fixed-priority variant is selected by the same macro. The scoreboard and output stage stay in `reg_wb_arbiter`.

## Test plan
- Reset: release `rst` → all outputs 0, `busy`=0. Then assert `rst` mid-write (`reg_wr_en`=1) → `reg_wr_en` drops before the next clock edge.
- Single write: req0 valid, addr=5, data=0xDEADBEEF in cycle T → `wb_ready[0]`=1 in T; `reg_wr_en`=1, addr=5, data=0xDEADBEEF in T+1; 0 in T+2.
- Round-robin: all 3 requesters valid for 6 cycles → grants in order 0,1,2,0,1,2. Without the macro → 0 granted every cycle.
- x0 write: req1 addr=0, data=0x1234 → `wb_ready[1]`=1; `reg_wr_en` stays 0.
- Scoreboard:
  - `rsv_en` with `rsv_addr`=7 → `busy[7]`=1 next cycle.
  - Write to r7 accepted in T → `busy[7]`=0 from T+2.
  - `rsv_en` with `rsv_addr`=0 → `busy` unchanged.
- Set/clear collision: commit to r9 (`reg_wr_en` high, addr=9) in the same cycle as `rsv_en` with `rsv_addr`=9 → `busy[9]` remains 1.

Source files
------------

// File: rtl/timberwolf_pkg.sv
// Shared core types: architectural register count, register address type and
// the write-back request record.
package timberwolf_pkg;
  localparam int NUM_ARCH_REG   = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int XLEN           = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Generic NUM_REQ-way one-hot grant generator. TIMBERWOLF_WB_RR_EN selects
// round-robin with a rotating pointer; otherwise the lowest index wins.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);
`ifdef TIMBERWOLF_WB_RR_EN
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // Walk requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx] && !found) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (idx == NUM_REQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic found;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter plus busy scoreboard. Arbitration policy is
// chosen by TIMBERWOLF_WB_RR_EN (round-robin) vs. fixed priority when undefined.
module reg_wb_arbiter
  import timberwolf_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REQ   = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      wb_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0]  wb_addr,
  input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]       wb_data,
  output logic [NUM_REQ-1:0]                      wb_ready,
  input  logic                                    rsv_en,
  input  reg_addr_t                               rsv_addr,
  output logic [NUM_ARCH_REG-1:0]                 busy,
  output logic                                    reg_wr_en,
  output reg_addr_t                               reg_wr_addr,
  output logic [REG_WIDTH-1:0]                    reg_wr_data
);
  logic [NUM_REQ-1:0]      gnt;
  logic                    acc;
  reg_addr_t               sel_addr;
  logic [REG_WIDTH-1:0]    sel_data;

  logic                    wr_en_q, wr_en_d;
  reg_addr_t               wr_addr_q, wr_addr_d;
  logic [REG_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [NUM_ARCH_REG-1:0] busy_q, busy_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst),
    .req   (wb_valid),
    .gnt   (gnt)
  );

  assign wb_ready = gnt & {NUM_REQ{rst}};
  assign acc      = |gnt;

  // Grant is one-hot, so an OR-reduction mux picks the winner.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | wb_addr[i];
        sel_data = sel_data | wb_data[i];
      end
    end
  end

  always_comb begin
    wr_en_d   = acc && (sel_addr != '0);
    wr_addr_d = acc ? sel_addr : wr_addr_q;
    wr_data_d = acc ? sel_data : wr_data_q;
    busy_d    = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    // Set after clear: a fresh reservation outlives the older write.
    if (rsv_en && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table, hand sequences for
// arbitration order and mid-write reset, then random traffic against a model.
module tb_reg_wb_arbiter;
  import timberwolf_pkg::*;

  localparam int N = 3;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        wb_valid;
  logic [N-1:0][4:0]   wb_addr;
  logic [N-1:0][W-1:0] wb_data;
  logic [N-1:0]        wb_ready;
  logic                rsv_en;
  logic [4:0]          rsv_addr;
  logic [31:0]         busy;
  logic                reg_wr_en;
  logic [4:0]          reg_wr_addr;
  logic [W-1:0]        reg_wr_data;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.REG_WIDTH(W), .NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .busy        (busy),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: rotation start, pending-write set, and port contents.
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          last_g;

  typedef struct {
    logic [2:0]  v;
    wb_req_t     req;
    logic        rsv;
    logic [4:0]  ra;
    logic [2:0]  e_rdy;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (wb_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a, input logic [31:0] d,
                              input logic rsv, input logic [4:0] ra, input logic [2:0] e_rdy,
                              input logic e_en, input logic [4:0] e_addr, input logic [31:0] e_busy);
    vec_t r;
    r.v = v; r.req.addr = a; r.req.data = d; r.rsv = rsv; r.ra = ra;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_addr = e_addr; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_en = 1'b0; m_addr = '0; m_data = '0; last_g = -1;
  endtask

  // Called at posedge+1; waits for the negedge and compares against the model.
  task automatic sample_check();
    logic [N-1:0] er;
    @(negedge clk);
    last_g = m_grant();
    er = '0;
    if (last_g >= 0) er[last_g] = 1'b1;
    chk("m_ready", 64'(wb_ready),    64'(er));
    chk("m_wr_en", 64'(reg_wr_en),   64'(m_en));
    chk("m_addr",  64'(reg_wr_addr), 64'(m_addr));
    chk("m_data",  64'(reg_wr_data), 64'(m_data));
    chk("m_busy",  64'(busy),        64'(m_busy));
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_en) m_busy[m_addr] = 1'b0;
    if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    if (last_g >= 0) begin
      m_en   = (wb_addr[last_g] != 5'd0);
      m_addr = wb_addr[last_g];
      m_data = wb_data[last_g];
`ifdef TIMBERWOLF_WB_RR_EN
      m_ptr  = (last_g + 1) % N;
`endif
    end else begin
      m_en = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] exp_rr;

    wb_valid = '0; wb_addr = '0; wb_data = '0; rsv_en = 1'b0; rsv_addr = '0;
    model_reset();

    tbl[0]  = mk(3'b001, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 3'b001, 1'b0, 5'd0, 32'h0);
    tbl[1]  = mk(3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 3'b000, 1'b1, 5'd5, 32'h80);
    tbl[2]  = mk(3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 3'b000, 1'b0, 5'd5, 32'h80);
    tbl[3]  = mk(3'b010, 5'd0, 32'h1234,     1'b0, 5'd0, 3'b010, 1'b0, 5'd5, 32'h80);
    tbl[4]  = mk(3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h80);
    tbl[5]  = mk(3'b001, 5'd7, 32'hAAAA5555, 1'b1, 5'd0, 3'b001, 1'b0, 5'd0, 32'h80);
    tbl[6]  = mk(3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 3'b000, 1'b1, 5'd7, 32'h80);
    tbl[7]  = mk(3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 3'b000, 1'b0, 5'd7, 32'h0);
    tbl[8]  = mk(3'b100, 5'd9, 32'h99,       1'b1, 5'd9, 3'b100, 1'b0, 5'd7, 32'h0);
    tbl[9]  = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd9, 3'b000, 1'b1, 5'd9, 32'h200);
    tbl[10] = mk(3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 3'b000, 1'b0, 5'd9, 32'h200);

    // Reset state, with requests present to show wb_ready is held low.
    wb_valid = 3'b111;
    #12;
    chk("rst_ready", 64'(wb_ready),    64'(0));
    chk("rst_wr_en", 64'(reg_wr_en),   64'(0));
    chk("rst_addr",  64'(reg_wr_addr), 64'(0));
    chk("rst_data",  64'(reg_wr_data), 64'(0));
    chk("rst_busy",  64'(busy),        64'(0));
    wb_valid = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 11; r++) begin
      wb_valid = tbl[r].v;
      for (int i = 0; i < N; i++) begin
        wb_addr[i] = tbl[r].req.addr;
        wb_data[i] = tbl[r].req.data;
      end
      rsv_en = tbl[r].rsv; rsv_addr = tbl[r].ra;
      sample_check();
      chk($sformatf("tbl%0d_ready", r), 64'(wb_ready),    64'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_wr_en", r), 64'(reg_wr_en),   64'(tbl[r].e_en));
      chk($sformatf("tbl%0d_addr",  r), 64'(reg_wr_addr), 64'(tbl[r].e_addr));
      chk($sformatf("tbl%0d_busy",  r), 64'(busy),        64'(tbl[r].e_busy));
      if (tbl[r].e_en) chk($sformatf("tbl%0d_data", r), 64'(reg_wr_data), 64'(r == 1 ? 32'hDEADBEEF : r == 6 ? 32'hAAAA5555 : 32'h99));
      advance();
    end

    // All requesters continuously valid: order of grants.
    rsv_en = 1'b0;
    wb_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      wb_addr[i] = 5'(i + 1);
      wb_data[i] = 32'h100 + i;
    end
    for (int c = 0; c < 6; c++) begin
      sample_check();
`ifdef TIMBERWOLF_WB_RR_EN
      exp_rr = 3'b001 << (c % 3);
`else
      exp_rr = 3'b001;
`endif
      chk($sformatf("order%0d", c), 64'(wb_ready), 64'(exp_rr));
      advance();
    end

    // Reset asserted while a committed write is on the port.
    wb_valid = 3'b001; wb_addr[0] = 5'd3; wb_data[0] = 32'h55;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    sample_check();
    advance();
    chk("pre_rst_wr_en", 64'(reg_wr_en), 64'(1));
    chk("pre_rst_busy12", 64'(busy[12]), 64'(1));
    rsv_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(reg_wr_en), 64'(0));
    chk("midrst_busy",  64'(busy),      64'(0));
    chk("midrst_ready", 64'(wb_ready),  64'(0));
    model_reset();
    wb_valid = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic; a request holds its payload until granted.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          wb_valid[i] = ($urandom_range(0, 3) != 0);
          wb_addr[i]  = 5'($urandom_range(0, 31));
          wb_data[i]  = $urandom;
        end
      end
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 31));
      sample_check();
      for (int i = 0; i < N; i++) pend[i] = wb_valid[i] && (last_g != i);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
